regfile_mp: RTL



---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_if.sv | 29 ++
 rtl/regfile_scoreboard.sv | 47 ++++
 rtl/regfile_mp.sv | 111 +++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;
   typedef enum logic {RF_INIT = 1'b0, RF_RUN = 1'b1} rf_state_t;

   localparam int DEF_WIDTH    = 64;
   localparam int DEF_DEPTH    = 32;
   localparam int DEF_NRD      = 2;
   localparam int DEF_NWR      = 2;
   localparam bit DEF_ZERO_REG = 1'b1;

   function automatic int slice_lo(input int idx, input int w);
      return idx * w;
   endfunction
endpackage

// File: rtl/regfile_if.sv
// Register file port bundle: write ports, read ports, scoreboard claim.
interface regfile_if import regfile_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int NRD   = DEF_NRD,
   parameter int NWR   = DEF_NWR
);
   localparam int AW = $clog2(DEPTH);

   logic                 p_ready;
   logic [NWR-1:0]       p_we;
   logic [NWR*AW-1:0]    p_waddr;
   logic [NWR*WIDTH-1:0] p_din;
   logic [NRD*AW-1:0]    p_raddr;
   logic [NRD*WIDTH-1:0] p_dout;
   logic [NRD-1:0]       p_rbusy;
   logic                 p_claim;
   logic [AW-1:0]        p_claim_addr;
   logic                 p_claim_ok;

   modport master (
      input  p_ready, p_dout, p_rbusy, p_claim_ok,
      output p_we, p_waddr, p_din, p_raddr, p_claim, p_claim_addr
   );
   modport slave (
      output p_ready, p_dout, p_rbusy, p_claim_ok,
      input  p_we, p_waddr, p_din, p_raddr, p_claim, p_claim_addr
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, claim accept,
// write-clear with a same-cycle accepted claim taking priority.
module regfile_scoreboard import regfile_pkg::*; #(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NWR      = DEF_NWR,
   parameter bit ZERO_REG = DEF_ZERO_REG
) (
   input  logic                           p_clk,
   input  logic                           p_rst,
   input  logic                           run,
   input  logic [NWR-1:0]                 we,
   input  logic [NWR*$clog2(DEPTH)-1:0]   waddr,
   input  logic                           claim,
   input  logic [$clog2(DEPTH)-1:0]       claim_addr,
   output logic                           claim_ok,
   output logic [DEPTH-1:0]               busy
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0] busy_q, busy_d, wr_hit;
   logic             claim_zero;

   always_comb begin
      wr_hit = '0;
      if (run) begin
         for (int w = 0; w < NWR; w++) begin
            if (we[w]) wr_hit[waddr[slice_lo(w, AW) +: AW]] = 1'b1;
         end
      end
   end

   // A write retiring the claimed register this cycle frees it for the new producer.
   always_comb begin
      claim_zero = ZERO_REG && (claim_addr == '0);
      claim_ok   = run && claim &&
                   (!busy_q[claim_addr] || wr_hit[claim_addr] || claim_zero);
      busy_d     = busy_q & ~wr_hit;
      if (claim_ok && !claim_zero) busy_d[claim_addr] = 1'b1;
   end

   always_ff @(posedge p_clk) begin
      if (p_rst) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   assign busy = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, write bypass, zero register and
// post-reset clear sweep; pending writes tracked by regfile_scoreboard.
module regfile_mp import regfile_pkg::*; #(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NRD      = DEF_NRD,
   parameter int NWR      = DEF_NWR,
   parameter bit ZERO_REG = DEF_ZERO_REG
) (
   input  logic     p_clk,
   input  logic     p_rst,
   regfile_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   rf_state_t        state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             run;
   logic             claim_ok;
   logic [DEPTH-1:0] busy;

   always_ff @(posedge p_clk) begin
      if (p_rst) begin
         state_q <= RF_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == RF_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == AW'(DEPTH - 1)) state_d = RF_RUN;
      end
   end

   always_comb begin
      run         = (state_q == RF_RUN);
      bus.p_ready = run;
   end

   // Ascending port order lets the higher index win a same-address collision.
   always_comb begin
      mem_d = mem_q;
      if (!run) begin
         mem_d[cnt_q] = '0;
      end else begin
         for (int w = 0; w < NWR; w++) begin
            if (bus.p_we[w] &&
                !(ZERO_REG && bus.p_waddr[slice_lo(w, AW) +: AW] == '0))
               mem_d[bus.p_waddr[slice_lo(w, AW) +: AW]] = bus.p_din[slice_lo(w, WIDTH) +: WIDTH];
         end
      end
   end

   always_ff @(posedge p_clk) begin
      mem_q <= mem_d;
   end

   regfile_scoreboard #(
      .DEPTH    (DEPTH),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .p_clk      (p_clk),
      .p_rst      (p_rst),
      .run        (run),
      .we         (bus.p_we),
      .waddr      (bus.p_waddr),
      .claim      (bus.p_claim),
      .claim_addr (bus.p_claim_addr),
      .claim_ok   (claim_ok),
      .busy       (busy)
   );

   assign bus.p_claim_ok = claim_ok;

   always_comb begin
      logic [AW-1:0]    ra;
      logic [WIDTH-1:0] data;
      logic             rb;
      ra          = '0;
      data        = '0;
      rb          = 1'b0;
      bus.p_dout  = '0;
      bus.p_rbusy = '0;
      for (int r = 0; r < NRD; r++) begin
         ra   = bus.p_raddr[slice_lo(r, AW) +: AW];
         data = '0;
         rb   = 1'b0;
         if (run && !(ZERO_REG && ra == '0)) begin
            data = mem_q[ra];
            rb   = busy[ra];
            for (int w = 0; w < NWR; w++) begin
               if (bus.p_we[w] && bus.p_waddr[slice_lo(w, AW) +: AW] == ra) begin
                  data = bus.p_din[slice_lo(w, WIDTH) +: WIDTH];
                  rb   = claim_ok && (bus.p_claim_addr == ra);
               end
            end
         end
         bus.p_dout[slice_lo(r, WIDTH) +: WIDTH] = data;
         bus.p_rbusy[r] = rb;
      end
   end
endmodule
